// File: rtl/gate2_exerciser_ctrl.sv
// Purpose : on-chip exerciser that walks a 2-input gate-under-test through
//           vectors 00,01,10,11 and checks each settled output against a
//           captured 4-bit truth table.
// Latency : done pulses 4*(SETTLE_CYCLES+1) cycles after an accepted start.
// Backpr. : start is ignored (not queued) outside IDLE; abort cancels a run.
// Ports   : clk/rst        - clock, async active-high reset
//           start/abort    - run request (IDLE only) / run cancel (SETTLE/SAMPLE only)
//           truth_table    - bit i = expected dut_z for vector i = {dut_a,dut_b}
//           dut_a/dut_b    - registered GUT stimulus; dut_z - GUT output
//           busy/done      - run in progress / one-cycle completion pulse
//           pass/fail_mask/err_count - results of the last run, held until next start
module gate2_exerciser_ctrl #(
  parameter int SETTLE_CYCLES = 4  // legal 1..15, counter is 4 bits wide
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_table,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_d;
  logic [1:0] vec, vec_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] exp_q, exp_d;
  logic [3:0] mask_d;
  logic [2:0] err_d;
  logic       pass_d;
  logic       a_d, b_d, busy_d, done_d;

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so nothing combinational reaches an output pin.
  always_comb begin
    state_d = state;
    vec_d   = vec;
    cnt_d   = cnt;
    exp_d   = exp_q;
    mask_d  = fail_mask;
    err_d   = err_count;
    pass_d  = pass;

    case (state)
      IDLE: begin
        // start beats abort here simply because abort is not looked at in IDLE
        if (start) begin
          exp_d   = truth_table;
          mask_d  = 4'b0000;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        // abort discards this cycle's compare; partial results stay visible
        if (abort) begin
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          state_d = IDLE;
        end else begin
          if (dut_z != exp_q[vec]) begin
            mask_d[vec] = 1'b1;
            err_d       = err_count + 3'd1;
          end
          if (vec == 2'd3) begin
            // pass must include the vector-3 result, hence err_d not err_count
            pass_d  = (err_d == 3'd0);
            state_d = FINISH;
          end else begin
            vec_d   = vec + 2'd1;
            cnt_d   = 4'd0;
            state_d = SETTLE;
          end
        end
      end

      FINISH: begin
        vec_d   = 2'd0;
        state_d = IDLE;
      end

      default: begin
        vec_d   = 2'd0;
        state_d = IDLE;
      end
    endcase

    // Stimulus follows the vector register while a run (or its FINISH cycle)
    // is active, and parks at 00 in IDLE.
    a_d    = (state_d != IDLE) ? vec_d[1] : 1'b0;
    b_d    = (state_d != IDLE) ? vec_d[0] : 1'b0;
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= 4'd0;
      exp_q     <= 4'b0000;
      fail_mask <= 4'b0000;
      err_count <= 3'd0;
      pass      <= 1'b0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      vec       <= vec_d;
      cnt       <= cnt_d;
      exp_q     <= exp_d;
      fail_mask <= mask_d;
      err_count <= err_d;
      pass      <= pass_d;
      dut_a     <= a_d;
      dut_b     <= b_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_gate2_exerciser_ctrl.sv
module tb_gate2_exerciser_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] truth_table;
  logic       dut_a, dut_b, dut_z;
  logic       busy, done, pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  // GUT models: 0 = OR built from NANDs, 1 = output tied 0, 2 = output tied 1
  logic [1:0] zmode;
  logic       n_a, n_b, or_z;
  assign n_a   = ~(dut_a & dut_a);
  assign n_b   = ~(dut_b & dut_b);
  assign or_z  = ~(n_a & n_b);
  assign dut_z = (zmode == 2'd0) ? or_z : (zmode == 2'd2);

  int applied = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  gate2_exerciser_ctrl #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .truth_table(truth_table), .dut_a(dut_a), .dut_b(dut_b), .dut_z(dut_z),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .err_count(err_count)
  );

  task automatic chk(input string nm, input int act, input int expv);
    applied++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  typedef struct {
    string      nm;
    logic [3:0] tt;
    logic [1:0] zm;
    logic [3:0] mask;
    logic [2:0] err;
    logic       ps;
  } vec_t;

  vec_t tbl[6];

  // Entered at a negedge in IDLE; leaves at the negedge of the IDLE cycle
  // right after done, so consecutive calls exercise the earliest restart.
  task automatic do_run(input vec_t v);
    zmode       = v.zm;
    truth_table = v.tt;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 21; c++) begin
      if (c == 2) truth_table = ~v.tt;  // must not affect the captured table
      if (c < 20) begin
        chk($sformatf("%s busy c%0d", v.nm, c), int'(busy), 1);
        chk($sformatf("%s ab c%0d", v.nm, c), int'({dut_a, dut_b}), c / 5);
      end
      chk($sformatf("%s done c%0d", v.nm, c), int'(done), int'(c == 20));
      if (c == 0) begin
        chk($sformatf("%s clr mask", v.nm), int'(fail_mask), 0);
        chk($sformatf("%s clr err", v.nm), int'(err_count), 0);
        chk($sformatf("%s clr pass", v.nm), int'(pass), 0);
      end
      if (c >= 20) begin
        chk($sformatf("%s mask c%0d", v.nm, c), int'(fail_mask), int'(v.mask));
        chk($sformatf("%s err c%0d", v.nm, c), int'(err_count), int'(v.err));
        chk($sformatf("%s pass c%0d", v.nm, c), int'(pass), int'(v.ps));
        chk($sformatf("%s busy c%0d", v.nm, c), int'(busy), 0);
      end
      if (c == 21) chk($sformatf("%s ab idle", v.nm), int'({dut_a, dut_b}), 0);
      if (c < 21) @(negedge clk);
    end
  endtask

  initial begin
    int dcount;

    tbl[0] = '{"or_ok",     4'b1110, 2'd0, 4'b0000, 3'd0, 1'b1};
    tbl[1] = '{"tied0",     4'b1110, 2'd1, 4'b1110, 3'd3, 1'b0};
    tbl[2] = '{"or_and",    4'b1000, 2'd0, 4'b0110, 3'd2, 1'b0};
    tbl[3] = '{"or_xor",    4'b0110, 2'd0, 4'b1000, 3'd1, 1'b0};
    tbl[4] = '{"tied1_all", 4'b0000, 2'd2, 4'b1111, 3'd4, 1'b0};
    tbl[5] = '{"tied1_ok",  4'b1111, 2'd2, 4'b0000, 3'd0, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; truth_table = 4'b0000; zmode = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst pass", int'(pass), 0);
    chk("rst mask", int'(fail_mask), 0);
    chk("rst err", int'(err_count), 0);
    chk("rst ab", int'({dut_a, dut_b}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_run(tbl[i]);

    // Extra starts mid-run and a table change after capture are ignored.
    zmode = 2'd0; truth_table = 4'b1110; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int c = 0; c <= 24; c++) begin
      start = (c == 3 || c == 12);
      if (c == 5) truth_table = 4'b0000;
      if (done) dcount++;
      if (c == 20) begin
        chk("ign done c20", int'(done), 1);
        chk("ign pass c20", int'(pass), 1);
      end
      if (c < 24) @(negedge clk);
    end
    start = 1'b0;
    chk("ign done count", dcount, 1);
    @(negedge clk);

    // start and abort together in IDLE: start wins; then abort in SETTLE.
    truth_table = 4'b1110; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa busy", int'(busy), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("settle abort busy", int'(busy), 0);
    chk("settle abort done", int'(done), 0);
    @(negedge clk);

    // Abort in the SAMPLE cycle of vector 2 discards that compare.
    zmode = 2'd1; truth_table = 4'b1110; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int c = 0; c <= 25; c++) begin
      abort = (c == 14);
      if (done) dcount++;
      if (c == 14) chk("ab pre ab", int'({dut_a, dut_b}), 2);
      if (c == 15) begin
        chk("ab busy", int'(busy), 0);
        chk("ab ab", int'({dut_a, dut_b}), 0);
        chk("ab mask", int'(fail_mask), 4'b0010);
        chk("ab err", int'(err_count), 1);
        chk("ab pass", int'(pass), 0);
      end
      if (c < 25) @(negedge clk);
    end
    abort = 1'b0;
    chk("ab no done", dcount, 0);
    chk("ab mask held", int'(fail_mask), 4'b0010);
    @(negedge clk);

    // Reset during SETTLE of vector 2 clears everything immediately.
    zmode = 2'd1; truth_table = 4'b1110; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid pre mask", int'(fail_mask), 4'b0010);
    chk("mid pre ab", int'({dut_a, dut_b}), 2);
    rst = 1'b1;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst ab", int'({dut_a, dut_b}), 0);
    chk("mid rst mask", int'(fail_mask), 0);
    chk("mid rst err", int'(err_count), 0);
    chk("mid rst pass", int'(pass), 0);
    chk("mid rst done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_run(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule

// File: doc/gate2_exerciser_ctrl.md
# gate2_exerciser_ctrl

Synthesizable self-checking controller that sequences a 2-input combinational gate-under-test (GUT), such as the NAND-built OR gate, through all four input vectors. It compares each settled output against a 4-bit expected truth table captured at start and reports per-vector mismatches, an error count, and pass/fail. It sits between a host/top-level start/status interface and the GUT's A/B/Z pins, replacing hand-written stimulus with an on-chip check.

## Interface
- SETTLE_CYCLES, default 4: cycles each vector is held before sampling Z; legal range 1..15. The settle counter width is 4 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  run request; accepted only in IDLE
- abort  input  1  synchronous run cancel; honoured only in SETTLE/SAMPLE
- truth_table  input  4  bit i = expected Z for vector i = {A,B}; captured on accepted start
- dut_a  output  1  GUT input A (vector bit 1)
- dut_b  output  1  GUT input B (vector bit 0)
- dut_z  input  1  GUT output
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  one-cycle pulse in FINISH
- pass  output  1  1 when the last completed run had zero mismatches
- fail_mask  output  4  bit i set if vector i mismatched
- err_count  output  3  number of mismatches, 0..4

## Operation
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - busy=0, dut_a=dut_b=0.
  - On start=1: capture truth_table into exp_q; clear fail_mask, err_count and pass; set vec=0 and settle counter=0; go to SETTLE.
- SETTLE:
  - {dut_a,dut_b} = vec, driven from registers (no combinational path from inputs).
  - The counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle), at the exiting edge:
  - If dut_z != exp_q[vec]: set fail_mask[vec] and increment err_count.
  - If vec==3, go to FINISH. Otherwise increment vec, clear the counter, and go to SETTLE; dut_a/dut_b take the new vector at this same edge.
- FINISH (one cycle):
  - done=1, busy=0.
  - pass = (err_count==0), using the final value that includes the vec-3 result.
  - Next state is IDLE; dut_a/dut_b return to 0.
- pass, fail_mask and err_count hold from FINISH until the next accepted start.
- abort in SETTLE/SAMPLE:
  - Next state is IDLE; dut_a/dut_b go to 0.
  - No done pulse, pass=0.
  - fail_mask and err_count keep their partial values.
  - abort takes priority over a SAMPLE compare in the same cycle: that compare is discarded.
- start while not in IDLE: ignored, with no queuing. start and abort together in IDLE: start wins.
- truth_table changes after capture have no effect on the current run.

## Timing
- Reset (asynchronous, immediate): state=IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, vec=0, counter=0, exp_q=0.
- Reset mid-run discards all results. The first start after reset release runs a full clean sequence.
- Start accepted at edge k:
  - busy=1 from cycle k.
  - Vector i is applied at edge k + i·(SETTLE_CYCLES+1).
  - dut_z for vector i is sampled at edge k + (i+1)·(SETTLE_CYCLES+1) − 0, i.e. the edge ending SAMPLE.
- done is high in cycle k + 4·(SETTLE_CYCLES+1), which is 20 cycles after acceptance for the default.
- The earliest next start is accepted one cycle after done, in IDLE.
- All outputs are registered. dut_z must settle within SETTLE_CYCLES clock periods.

## Test plan
- Correct OR-from-NAND GUT, truth_table=4'b1110, SETTLE_CYCLES=4, start pulse → vectors 00,01,10,11 each held 5 cycles; done at cycle 20; pass=1, fail_mask=0000, err_count=0.
- dut_z tied 0, truth_table=4'b1110 → fail_mask=1110, err_count=3, pass=0; done still at cycle 20.
- OR GUT with AND table 4'b1000 → fail_mask=0110, err_count=2, pass=0.
- Start pulsed again at cycles 3 and 12, and truth_table changed to 4'b0000 at cycle 5, during an OR run with table 4'b1110 → only one run occurs, one done pulse at cycle 20, pass=1.
- rst asserted during SETTLE of vector 2 → all outputs 0 immediately, busy=0. A later start with table 4'b1110 gives a full 20-cycle run with pass=1.
- dut_z tied 0, table 4'b1110, abort asserted in the SAMPLE cycle of vector 2 → IDLE next cycle, no done, pass=0, fail_mask=0010, err_count=1; dut_a=dut_b=0.
